// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC select, I-SRAM request, stall buffer.
// Optional IF_PERF_CNT_EN adds fetch/cancel event counters.
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [64:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [95:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [63:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] cancel_cnt
`endif
);

  logic        br_taken;
  logic [63:0] br_target;
  logic        to_fs_valid;
  logic        fs_allowin;
  logic [63:0] nextpc;
  logic [31:0] fs_inst;

  logic        fs_valid_q, fs_valid_d;
  logic [63:0] fs_pc_q, fs_pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [63:0] pend_pc_q, pend_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_q, buf_d;
  logic        fresh_q, fresh_d;

  assign br_taken  = br_bus[64];
  assign br_target = br_bus[63:0];

  assign to_fs_valid = !reset;
  assign fs_allowin  = !fs_valid_q || ds_allowin;

  always_comb begin
    nextpc = fs_pc_q + 64'd4;
    if (pend_valid_q) nextpc = pend_pc_q;
    else if (br_taken) nextpc = br_target;
  end

  assign inst_sram_en   = to_fs_valid && fs_allowin;
  assign inst_sram_addr = nextpc;

  assign fs_to_ds_valid = fs_valid_q && !br_taken;
  assign fs_inst        = buf_valid_q ? buf_q : inst_sram_rdata;
  assign fs_to_ds_bus   = {fs_inst, fs_pc_q};

  always_comb begin
    fs_valid_d   = fs_valid_q;
    fs_pc_d      = fs_pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    buf_valid_d  = buf_valid_q;
    buf_d        = buf_q;
    fresh_d      = inst_sram_en;

    if (fs_allowin) fs_valid_d = to_fs_valid;
    else if (br_taken) fs_valid_d = 1'b0;

    if (inst_sram_en) fs_pc_d = nextpc;

    // Redirect arriving during a stall is remembered until it can be fetched.
    if (br_taken && !fs_allowin) begin
      pend_pc_d    = br_target;
      pend_valid_d = 1'b1;
    end else if (inst_sram_en) begin
      pend_valid_d = 1'b0;
    end

    if (fs_allowin || br_taken) begin
      buf_valid_d = 1'b0;
    end else if (fresh_q && fs_valid_q
                 && !(fs_to_ds_valid && ds_allowin)) begin
      buf_d       = inst_sram_rdata;
      buf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q   <= 1'b0;
      fs_pc_q      <= RESET_PC - 64'd4;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 64'h0;
      buf_valid_q  <= 1'b0;
      buf_q        <= 32'h0;
      fresh_q      <= 1'b0;
    end else begin
      fs_valid_q   <= fs_valid_d;
      fs_pc_q      <= fs_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      buf_valid_q  <= buf_valid_d;
      buf_q        <= buf_d;
      fresh_q      <= fresh_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, cancel_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= 32'h0;
      cancel_cnt_q <= 32'h0;
    end else begin
      if (fs_to_ds_valid && ds_allowin) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (fs_valid_q && br_taken) cancel_cnt_q <= cancel_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign cancel_cnt = cancel_cnt_q;
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV64 pipeline; sits directly upstream of id_stage.
- Generates the next PC (sequential or redirected by br_bus) and drives the synchronous instruction SRAM.
- Buffers returned instructions across decode stalls.
- Presents {inst, pc} on the 96-bit fs_to_ds_bus using the valid/allowin handshake.

Parameters:
RESET_PC, 64'h0000_0000_0000_0000, address of the first instruction fetched after reset.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
ds_allowin  input  1  id_stage can accept an instruction this cycle
br_bus  input  65  {br_taken[64], br_target[63:0]} from id_stage
fs_to_ds_valid  output  1  fs_to_ds_bus carries a valid instruction
fs_to_ds_bus  output  96  {fs_inst[31:0], fs_pc[63:0]}
inst_sram_en  output  1  instruction SRAM read enable
inst_sram_addr  output  64  read address (byte address, word aligned)
inst_sram_rdata  input  32  read data; valid the cycle after inst_sram_en, undefined otherwise

Behaviour:
Pre-IF:
- to_fs_valid = !reset.
- nextpc = br_pend_valid ? br_pend_pc : (br_taken ? br_target : fs_pc + 4). The add wraps modulo 2^64.
- inst_sram_en = to_fs_valid && fs_allowin.
- inst_sram_addr = nextpc.

IF stage:
- fs_ready_go = 1.
- fs_allowin = !fs_valid || ds_allowin.
- fs_to_ds_valid = fs_valid && !br_taken. The instruction presented while br_taken=1 is wrong-path and is never accepted.
- On a clock edge with fs_allowin=1: fs_valid <= to_fs_valid. If inst_sram_en=1, also fs_pc <= nextpc.

Reset:
- fs_valid=0, fs_pc=RESET_PC-4, br_pend_valid=0, inst_buf_valid=0, rdata_fresh=0.
- Outputs during reset: fs_to_ds_valid=0, inst_sram_en=0.
- First cycle after reset deasserts: inst_sram_en=1, inst_sram_addr=RESET_PC.
- First instruction is valid on fs_to_ds_bus one cycle later. Fetch latency is 1 cycle.

Instruction buffer:
- rdata_fresh <= inst_sram_en, registered every cycle.
- fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
- Capture: if rdata_fresh && fs_valid && !(fs_to_ds_valid && ds_allowin), then inst_buf <= inst_sram_rdata and inst_buf_valid <= 1.
- Clear inst_buf_valid when fs_allowin=1 or on a branch cancel.
- Required property: fs_inst stays stable for the entire stall, however long.

Branch redirect:
- br_taken is a one-cycle pulse; br_target[1:0] is always 00.
- br_taken with fs_allowin=1: fetch br_target this cycle. The current IF instruction is dropped (fs_to_ds_valid gated).
- br_taken with fs_allowin=0, which occurs only when fs_valid=1 and ds_allowin=0:
  - br_pend_pc <= br_target; br_pend_valid <= 1.
  - fs_valid <= 0 and inst_buf_valid <= 0.
  - The next cycle fetches br_pend_pc.
  - br_pend_valid clears on the edge where inst_sram_en=1.
- A second br_taken while br_pend_valid=1 overwrites br_pend_pc.

Simultaneous events:
- Reset dominates everything and discards any pending redirect.
- br_taken together with ds_allowin=1: the redirect wins and no instruction transfers.

Output qualification:
- fs_to_ds_bus is meaningful only when fs_to_ds_valid=1.
- It is held constant while fs_valid=1 and ds_allowin=0.

Optional Feature:
Macro: IF_PERF_CNT_EN
- Defined:
  - Adds output ports fetch_cnt[31:0] and cancel_cnt[31:0]; both reset to 0 and wrap at 2^32.
  - fetch_cnt increments each cycle fs_to_ds_valid && ds_allowin.
  - cancel_cnt increments each cycle fs_valid && br_taken.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset release, RESET_PC=0, ds_allowin=1, rdata sequence 00000113, 00510193, 00100a13 → inst_sram_addr 0,4,8 on consecutive cycles. fs_to_ds_bus = 96'h00000113_0000000000000000, then 96'h00510193_0000000000000004, then 96'h00100a13_0000000000000008.
2. Hold ds_allowin=0 for 5 cycles with pc=4 in IF, SRAM driving garbage after the first cycle → bus stays 96'h00510193_0000000000000004 throughout. inst_sram_en=0 during the stall. After release the next address is 8.
3. br_bus={1,64'h100} pulse while pc=8 in IF, ds_allowin=1 → fs_to_ds_valid=0 that cycle and inst_sram_addr=0x100. Next valid pc is 0x100, then 0x104.
4. br_taken with target 0x200 during a ds_allowin=0 stall → fs_valid drops the next cycle. The following fetch is 0x200 even though the branch pulse is gone. Pc 0x8+4 is never presented.
5. Assert reset mid-stream with br_pend_valid=1 → fs_to_ds_valid=0 during reset. Fetch restarts at RESET_PC; the pending target is not fetched.
6. IF_PERF_CNT_EN defined, run scenario 1 for 3 instructions plus scenario 3 → fetch_cnt=3 before the branch and cancel_cnt=1 after it.
